multicycle_ctrl_fsm: RTL and testbench

//  Parametrised multicycle CPU control FSM: fetch, decode, execute, memory and writeback sequencing.

---
 rtl/multicycle_ctrl_fsm_if.sv | 25 ++
 rtl/multicycle_ctrl_fsm.sv | 261 ++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_fsm_if.sv
// rtl/multicycle_ctrl_fsm_if.sv - memory handshake bundle between the control FSM and instruction/data memory
//  mem_req   controller -> memory  access request, held until acknowledged
//  ram_w_en  controller -> memory  store strobe, meaningful only with mem_req
//  sel_addr  controller -> memory  0 = PC address, 1 = data address register
//  mem_ack   memory -> controller  access done, honoured only while mem_req=1
interface multicycle_ctrl_fsm_if;
    logic mem_req;
    logic ram_w_en;
    logic sel_addr;
    logic mem_ack;

    modport master (
        output mem_req,
        output ram_w_en,
        output sel_addr,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  ram_w_en,
        input  sel_addr,
        output mem_ack
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multicycle CPU control FSM (fetch/decode/execute/mem/writeback)
//  Parameters: ALU_OP_W (alu_op width, >=3), Z_BIT (Z flag index in status_reg),
//              MEM_TIMEOUT (cycles without mem_ack before FAULT, 0 disables)
//  Ports:
//   clk, rst                 clock, synchronous active-high reset
//   opcode[6:0]              registered IR opcode
//   status_reg[31:0]         flags, only status_reg[Z_BIT] is read
//   mem (master modport)     mem_req / ram_w_en / sel_addr / mem_ack handshake
//   load_addr, load_ir, load_pc, clear_pc             address/IR/PC strobes
//   en_A, en_B, en_S, en_C, en_status                 datapath register enables
//   sel_A, sel_B, sel_shift, alu_op, wb_sel, w_en     datapath selects and writeback
//   waiting, fault           running indicator, sticky memory-timeout flag
//  Optional: define CTRL_PERF_CNT_EN to add retired_cnt[31:0] and cycle_cnt[31:0].
module multicycle_ctrl_fsm #(
    parameter int ALU_OP_W    = 3,
    parameter int Z_BIT       = 30,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [6:0]               opcode,
    input  logic [31:0]              status_reg,
    multicycle_ctrl_fsm_if.master    mem,
    output logic                     load_addr,
    output logic                     load_ir,
    output logic                     load_pc,
    output logic                     clear_pc,
    output logic                     en_A,
    output logic                     en_B,
    output logic                     en_S,
    output logic                     en_C,
    output logic                     en_status,
    output logic                     sel_A,
    output logic                     sel_B,
    output logic                     sel_shift,
    output logic [ALU_OP_W-1:0]      alu_op,
    output logic [1:0]               wb_sel,
    output logic                     w_en,
    output logic                     waiting,
    output logic                     fault
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]              retired_cnt,
    output logic [31:0]              cycle_cnt
`endif
);

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_HALT,
        S_FAULT
    } state_e;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_ORR = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] ALU_XOR = ALU_OP_W'(7);

    // Counter only has to reach MEM_TIMEOUT-1; expiry is detected on the last un-acked cycle.
    localparam int                 CNT_W      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int                 TMO_LAST_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0]   TMO_LAST   = CNT_W'(TMO_LAST_I);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;

    // Opcode classification
    logic is_alu, is_br, is_ls, is_nop, is_hlt, is_movi, is_cmp;
    logic br_legal, br_taken, is_bl, z_flag, ls_l, ls_u, ls_w, tmo_expire;
    logic [ALU_OP_W-1:0] alu_fn;

    assign is_alu  = ~opcode[6];
    assign is_br   = (opcode[6:5] == 2'b10);
    assign is_ls   = (opcode[6:5] == 2'b11);
    assign is_nop  = (opcode == 7'b0000000);
    assign is_hlt  = (opcode == 7'b0000001);
    assign is_movi = (opcode == 7'b0011000);
    assign is_cmp  = is_alu && (opcode[2:0] == 3'b010);
    assign ls_l    = opcode[0];
    assign ls_u    = opcode[2];
    assign ls_w    = opcode[3];
    assign z_flag  = status_reg[Z_BIT];
    assign is_bl   = (opcode[2:0] == 3'b010);

    // Only B, BL, BEQ and BNE exist; other branch encodings fall back to NOP in DECODE.
    assign br_legal = (opcode[2:0] == 3'b000) || (opcode[2:0] == 3'b010) ||
                      (opcode[2:0] == 3'b100) || (opcode[2:0] == 3'b101);
    assign br_taken = (opcode[2:0] == 3'b000) || is_bl ||
                      ((opcode[2:0] == 3'b100) && z_flag) ||
                      ((opcode[2:0] == 3'b101) && !z_flag);

    assign tmo_expire = (MEM_TIMEOUT > 0) && (tmo_cnt_q == TMO_LAST);

    logic unused_status;
    assign unused_status = ^status_reg;

    always_comb begin
        alu_fn = ALU_ADD;
        case (opcode[2:0])
            3'b000:         alu_fn = ALU_ADD;
            3'b001, 3'b010: alu_fn = ALU_SUB;
            3'b011:         alu_fn = ALU_AND;
            3'b100:         alu_fn = ALU_ORR;
            3'b101:         alu_fn = ALU_XOR;
            default:        alu_fn = ALU_ADD;
        endcase
    end

    // Next state and timeout counter
    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                // An ack on the expiry cycle still completes the access.
                if (mem.mem_ack)     state_d = S_DECODE;
                else if (tmo_expire) state_d = S_FAULT;
                else                 tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
            end
            S_DECODE: begin
                if (is_nop)                  state_d = S_FETCH;
                else if (is_hlt)             state_d = S_HALT;
                else if (is_movi)            state_d = S_WRITEBACK;
                else if (is_alu || is_ls)    state_d = S_EXECUTE;
                else if (is_br && br_legal)  state_d = S_EXECUTE;
                else                         state_d = S_FETCH;
            end
            S_EXECUTE: begin
                if (is_ls)                   state_d = S_MEM;
                else if (is_alu && !is_cmp)  state_d = S_WRITEBACK;
                else                         state_d = S_FETCH;
            end
            S_MEM: begin
                if (mem.mem_ack)     state_d = (ls_l || ls_w) ? S_WRITEBACK : S_FETCH;
                else if (tmo_expire) state_d = S_FAULT;
                else                 tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
            end
            S_WRITEBACK: state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            S_FAULT:     state_d = S_FAULT;
            default:     state_d = S_RESET;
        endcase
        if ((state_d == S_FETCH || state_d == S_MEM) && (state_d != state_q))
            tmo_cnt_d = '0;
    end

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] retired_cnt_q, cycle_cnt_q;
    logic        retire;
    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_DECODE) || (state_q == S_EXECUTE) ||
                     (state_q == S_MEM) || (state_q == S_WRITEBACK));
    assign retired_cnt = retired_cnt_q;
    assign cycle_cnt   = cycle_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RESET;
            tmo_cnt_q <= '0;
`ifdef CTRL_PERF_CNT_EN
            retired_cnt_q <= '0;
            cycle_cnt_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
`ifdef CTRL_PERF_CNT_EN
            if (state_q != S_HALT && state_q != S_FAULT) begin
                cycle_cnt_q <= cycle_cnt_q + 32'd1;
                if (retire) retired_cnt_q <= retired_cnt_q + 32'd1;
            end
`endif
        end
    end

    // Outputs are decoded from the registered state and registered IR; the fetch
    // strobes additionally follow mem_ack so IR/PC load on the completing cycle.
    always_comb begin
        mem.mem_req  = 1'b0;
        mem.ram_w_en = 1'b0;
        mem.sel_addr = 1'b0;
        load_addr    = 1'b0;
        load_ir      = 1'b0;
        load_pc      = 1'b0;
        clear_pc     = 1'b0;
        en_A         = 1'b0;
        en_B         = 1'b0;
        en_S         = 1'b0;
        en_C         = 1'b0;
        en_status    = 1'b0;
        sel_A        = 1'b0;
        sel_B        = 1'b0;
        sel_shift    = 1'b0;
        alu_op       = ALU_ADD;
        wb_sel       = 2'd0;
        w_en         = 1'b0;
        waiting      = 1'b1;
        fault        = 1'b0;
        case (state_q)
            S_RESET: clear_pc = 1'b1;
            S_FETCH: begin
                mem.mem_req = 1'b1;
                load_ir     = mem.mem_ack;
                load_pc     = mem.mem_ack;
            end
            S_DECODE: begin
                if (is_alu && !is_nop && !is_hlt && !is_movi) begin
                    en_A      = opcode[3];
                    en_B      = opcode[4];
                    en_S      = opcode[4];
                    sel_shift = opcode[5];
                end else if (is_ls) begin
                    en_A = 1'b1;
                end
            end
            S_EXECUTE: begin
                if (is_alu) begin
                    sel_A     = ~opcode[3];
                    sel_B     = ~opcode[4];
                    alu_op    = alu_fn;
                    en_C      = ~is_cmp;
                    en_status = is_cmp;
                end else if (is_br) begin
                    load_pc = br_taken;
                    if (is_bl) begin
                        w_en   = 1'b1;
                        wb_sel = 2'd3;
                    end
                end else begin
                    alu_op    = ls_u ? ALU_ADD : ALU_SUB;
                    load_addr = 1'b1;
                    en_C      = 1'b1;
                end
            end
            S_MEM: begin
                mem.mem_req  = 1'b1;
                mem.sel_addr = 1'b1;
                mem.ram_w_en = ~ls_l;
            end
            S_WRITEBACK: begin
                w_en   = 1'b1;
                wb_sel = (is_ls && ls_l) ? 2'd2 : 2'd1;
            end
            S_HALT:  waiting = 1'b0;
            S_FAULT: begin
                waiting = 1'b0;
                fault   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - directed self-checking bench for multicycle_ctrl_fsm
module tb_multicycle_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic [31:0] status_reg;
    logic        load_addr, load_ir, load_pc, clear_pc;
    logic        en_A, en_B, en_S, en_C, en_status;
    logic        sel_A, sel_B, sel_shift;
    logic [2:0]  alu_op;
    logic [1:0]  wb_sel;
    logic        w_en, waiting, fault;
    int          n_chk = 0;
    int          n_err = 0;

    multicycle_ctrl_fsm_if mem_if ();

    multicycle_ctrl_fsm #(
        .ALU_OP_W    (3),
        .Z_BIT       (30),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .status_reg (status_reg),
        .mem        (mem_if.master),
        .load_addr  (load_addr),
        .load_ir    (load_ir),
        .load_pc    (load_pc),
        .clear_pc   (clear_pc),
        .en_A       (en_A),
        .en_B       (en_B),
        .en_S       (en_S),
        .en_C       (en_C),
        .en_status  (en_status),
        .sel_A      (sel_A),
        .sel_B      (sel_B),
        .sel_shift  (sel_shift),
        .alu_op     (alu_op),
        .wb_sel     (wb_sel),
        .w_en       (w_en),
        .waiting    (waiting),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    // Output snapshot layout, msb first
    localparam logic [22:0] MREQ = 23'(1) << 22;
    localparam logic [22:0] RWE  = 23'(1) << 21;
    localparam logic [22:0] SADR = 23'(1) << 20;
    localparam logic [22:0] LADR = 23'(1) << 19;
    localparam logic [22:0] LIR  = 23'(1) << 18;
    localparam logic [22:0] LPC  = 23'(1) << 17;
    localparam logic [22:0] CLR  = 23'(1) << 16;
    localparam logic [22:0] EA   = 23'(1) << 15;
    localparam logic [22:0] EB   = 23'(1) << 14;
    localparam logic [22:0] ES   = 23'(1) << 13;
    localparam logic [22:0] EC   = 23'(1) << 12;
    localparam logic [22:0] EST  = 23'(1) << 11;
    localparam logic [22:0] SA   = 23'(1) << 10;
    localparam logic [22:0] SB   = 23'(1) << 9;
    localparam logic [22:0] SSH  = 23'(1) << 8;
    localparam logic [22:0] WEN  = 23'(1) << 2;
    localparam logic [22:0] WT   = 23'(1) << 1;
    localparam logic [22:0] FLT  = 23'(1) << 0;

    function automatic logic [22:0] alu(input int n);
        return 23'(n) << 5;
    endfunction

    function automatic logic [22:0] wbs(input int n);
        return 23'(n) << 3;
    endfunction

    logic [22:0] obs;
    assign obs = {mem_if.mem_req, mem_if.ram_w_en, mem_if.sel_addr, load_addr, load_ir, load_pc,
                  clear_pc, en_A, en_B, en_S, en_C, en_status, sel_A, sel_B, sel_shift,
                  alu_op, wb_sel, w_en, waiting, fault};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Check the current cycle's outputs, then advance to the next low phase.
    task automatic cyc(input string tag, input logic [22:0] exp);
        #1;
        check_eq(tag, {9'd0, obs}, {9'd0, exp});
        @(negedge clk);
    endtask

    task automatic do_fetch(input string tag, input logic [6:0] op, input int waits);
        mem_if.mem_ack = 1'b0;
        for (int i = 0; i < waits; i++) cyc({tag, "_fwait"}, MREQ | WT);
        mem_if.mem_ack = 1'b1;
        cyc({tag, "_fetch"}, MREQ | LIR | LPC | WT);
        mem_if.mem_ack = 1'b0;
        opcode = op;
    endtask

    task automatic alu_seq(input string tag, input logic [6:0] op,
                           input logic [22:0] dec, input logic [22:0] exe);
        do_fetch(tag, op, 0);
        cyc({tag, "_dec"}, dec | WT);
        cyc({tag, "_exe"}, exe | WT);
        cyc({tag, "_wb"}, WEN | wbs(1) | WT);
    endtask

    typedef struct {
        string      tag;
        logic [6:0] op;
        logic [22:0] dec;
        logic [22:0] exe;
    } alu_vec_t;

    alu_vec_t alu_tab[6];

    initial begin
        alu_tab[0] = '{"add_rr",  7'b0111000, EA | EB | ES | SSH, EC | alu(0)};
        alu_tab[1] = '{"add_0100", 7'b0100000, SSH,               SA | SB | EC | alu(0)};
        alu_tab[2] = '{"sub",     7'b0001001, EA,                 SB | EC | alu(1)};
        alu_tab[3] = '{"and",     7'b0010011, EB | ES,            SA | EC | alu(2)};
        alu_tab[4] = '{"orr",     7'b0001100, EA,                 SB | EC | alu(3)};
        alu_tab[5] = '{"xor",     7'b0000101, 23'd0,              SA | SB | EC | alu(7)};

        rst = 1'b1;
        opcode = 7'd0;
        status_reg = 32'd0;
        mem_if.mem_ack = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state, then MOV_I with ack on the first fetch cycle
        cyc("reset_hold", CLR | WT);
        rst = 1'b0;
        cyc("reset_state", CLR | WT);
        do_fetch("movi", 7'b0011000, 0);
        cyc("movi_dec", WT);
        cyc("movi_wb", WEN | wbs(1) | WT);

        foreach (alu_tab[k]) alu_seq(alu_tab[k].tag, alu_tab[k].op, alu_tab[k].dec, alu_tab[k].exe);

        // CMP: flags only, straight back to FETCH
        do_fetch("cmp", 7'b0010010, 0);
        cyc("cmp_dec", EB | ES | WT);
        cyc("cmp_exe", SA | EST | alu(1) | WT);

        // Load, U=0, three wait cycles then ack on the timeout-expiry cycle
        do_fetch("ld", 7'b1100001, 2);
        cyc("ld_dec", EA | WT);
        cyc("ld_exe", alu(1) | LADR | EC | WT);
        for (int i = 0; i < 3; i++) cyc("ld_mwait", MREQ | SADR | WT);
        mem_if.mem_ack = 1'b1;
        cyc("ld_mack", MREQ | SADR | WT);
        mem_if.mem_ack = 1'b0;
        cyc("ld_wb", WEN | wbs(2) | WT);

        // Store with writeback of base, then store without
        do_fetch("stw", 7'b1101100, 0);
        cyc("stw_dec", EA | WT);
        cyc("stw_exe", alu(0) | LADR | EC | WT);
        mem_if.mem_ack = 1'b1;
        cyc("stw_mem", MREQ | SADR | RWE | WT);
        mem_if.mem_ack = 1'b0;
        cyc("stw_wb", WEN | wbs(1) | WT);
        do_fetch("st", 7'b1100100, 0);
        cyc("st_dec", EA | WT);
        cyc("st_exe", alu(0) | LADR | EC | WT);
        mem_if.mem_ack = 1'b1;
        cyc("st_mem", MREQ | SADR | RWE | WT);

        // Branches
        status_reg = 32'h4000_0000;
        do_fetch("beq_t", 7'b1000100, 0);
        cyc("beq_t_dec", WT);
        cyc("beq_t_exe", LPC | WT);
        status_reg = 32'h0000_0000;
        do_fetch("beq_n", 7'b1000100, 0);
        cyc("beq_n_dec", WT);
        cyc("beq_n_exe", WT);
        do_fetch("bne_t", 7'b1000101, 0);
        cyc("bne_t_dec", WT);
        cyc("bne_t_exe", LPC | WT);
        do_fetch("b", 7'b1000000, 0);
        cyc("b_dec", WT);
        cyc("b_exe", LPC | WT);
        do_fetch("bl", 7'b1000010, 0);
        cyc("bl_dec", WT);
        cyc("bl_exe", LPC | WEN | wbs(3) | WT);

        // NOP and an undefined branch type both return to FETCH after DECODE
        do_fetch("nop", 7'b0000000, 0);
        cyc("nop_dec", WT);
        do_fetch("ill", 7'b1000011, 0);
        cyc("ill_dec", WT);

        // Fetch timeout: four un-acked cycles then FAULT, sticky, ack ignored
        do_fetch("tmo", 7'b0000000, 0);
        cyc("tmo_dec", WT);
        for (int i = 0; i < 4; i++) cyc("tmo_fwait", MREQ | WT);
        cyc("tmo_fault", FLT);
        mem_if.mem_ack = 1'b1;
        cyc("tmo_sticky", FLT);
        mem_if.mem_ack = 1'b0;
        rst = 1'b1;
        cyc("tmo_pre_rst", FLT);
        cyc("tmo_rst", CLR | WT);
        rst = 1'b0;
        cyc("tmo_rst_rel", CLR | WT);

        // Reset in the middle of a fetch drops mem_req and ignores the ack
        cyc("mid_fetch", MREQ | WT);
        rst = 1'b1;
        mem_if.mem_ack = 1'b1;
        cyc("mid_ack", MREQ | LIR | LPC | WT);
        cyc("mid_rst", CLR | WT);
        rst = 1'b0;
        mem_if.mem_ack = 1'b0;
        cyc("mid_rel", CLR | WT);

        // HALT is sticky
        do_fetch("hlt", 7'b0000001, 0);
        cyc("hlt_dec", WT);
        cyc("hlt_0", 23'd0);
        mem_if.mem_ack = 1'b1;
        cyc("hlt_1", 23'd0);
        cyc("hlt_2", 23'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
